// File: rtl/rle_param.sv
// rtl/rle_param.sv - byte run-length encoder reading and writing a single-port DPSRAM
// Optional feature macro: RLE_CHECKSUM_EN (adds a 32-bit byte-sum output).
module rle_param #(
  parameter int ADDR_W  = 16,
  parameter int MAX_RUN = 255
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              busy,
`ifdef RLE_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SCAN, WR, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [31:0]       remaining;
  logic [1:0]        idx;
  logic [31:0]       word_reg;
  logic [7:0]        run_sym, run_cnt;
  logic              run_valid;
  logic [15:0]       pend_lo;
  logic              have_lo;

  logic              start_ok, consume, flush, extend, emit, full;
  logic [7:0]        byte_cur;
  logic [15:0]       pair;
  logic [31:0]       wr_word, wr_inc;

  assign port_A_clk = clk;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= next_state;
  end

  // Byte evaluation and next-state selection
  always_comb begin
    start_ok   = ((state == IDLE) || (state == DONE)) && start;
    byte_cur   = word_reg[{idx, 3'b000} +: 8];
    consume    = (state == SCAN) && (remaining != 32'd0);
    flush      = (state == SCAN) && (remaining == 32'd0) && run_valid;
    extend     = consume && run_valid && (byte_cur == run_sym) && (run_cnt < MAX_CNT);
    emit       = (consume && run_valid && !extend) || flush;
    pair       = {run_sym, run_cnt};
    full       = emit && (have_lo || flush);
    wr_word    = have_lo ? {pair, pend_lo} : {16'h0000, pair};
    wr_inc     = have_lo ? 32'd4 : 32'd2;
    next_state = state;
    case (state)
      IDLE, DONE: if (start_ok) next_state = (message_size == 32'd0) ? SCAN : RD_REQ;
      RD_REQ:     next_state = RD_WAIT;
      RD_WAIT:    next_state = SCAN;
      SCAN: begin
        if (full)                          next_state = WR;
        else if (consume) begin
          if (remaining == 32'd1)          next_state = SCAN;
          else if (idx == 2'd3)            next_state = RD_REQ;
          else                             next_state = SCAN;
        end else                           next_state = DONE;
      end
      WR: begin
        if (remaining == 32'd0)            next_state = run_valid ? SCAN : DONE;
        else if (idx == 2'd0)              next_state = RD_REQ;
        else                               next_state = SCAN;
      end
      default:                             next_state = IDLE;
    endcase
  end

  // Datapath: frame setup, run tracking, pair packing and memory port drive
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_addr        <= '0;
      wr_addr        <= '0;
      remaining      <= '0;
      idx            <= '0;
      word_reg       <= '0;
      run_sym        <= '0;
      run_cnt        <= '0;
      run_valid      <= 1'b0;
      pend_lo        <= '0;
      have_lo        <= 1'b0;
      rle_size       <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      port_A_addr    <= '0;
      port_A_we      <= 1'b0;
      port_A_data_in <= '0;
`ifdef RLE_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      port_A_we <= 1'b0;
      if (start_ok) begin
        remaining <= message_size;
        idx       <= '0;
        run_valid <= 1'b0;
        run_cnt   <= '0;
        have_lo   <= 1'b0;
        rle_size  <= '0;
        done      <= 1'b0;
        busy      <= 1'b1;
        wr_addr   <= rle_addr[ADDR_W-1:0];
`ifdef RLE_CHECKSUM_EN
        checksum  <= '0;
`endif
        if (message_size != 32'd0) begin
          port_A_addr <= message_addr[ADDR_W-1:0];
          rd_addr     <= message_addr[ADDR_W-1:0] + ADDR_W'(4);
        end else begin
          rd_addr     <= message_addr[ADDR_W-1:0];
        end
      end
      if (state == RD_WAIT) word_reg <= port_A_data_out;
      if (consume) begin
        remaining <= remaining - 32'd1;
        idx       <= idx + 2'd1;
`ifdef RLE_CHECKSUM_EN
        checksum  <= checksum + {24'h0, byte_cur};
`endif
        if (extend) begin
          run_cnt <= run_cnt + 8'd1;
        end else begin
          run_sym   <= byte_cur;
          run_cnt   <= 8'd1;
          run_valid <= 1'b1;
        end
      end
      if (flush) run_valid <= 1'b0;
      if (emit && !full) begin
        pend_lo <= pair;
        have_lo <= 1'b1;
      end
      if (full) begin
        port_A_we      <= 1'b1;
        port_A_addr    <= wr_addr;
        port_A_data_in <= wr_word;
        wr_addr        <= wr_addr + ADDR_W'(4);
        rle_size       <= rle_size + wr_inc;
        have_lo        <= 1'b0;
      end
      if (((state == SCAN) || (state == WR)) && (next_state == RD_REQ)) begin
        port_A_addr <= rd_addr;
        rd_addr     <= rd_addr + ADDR_W'(4);
      end
      if (((state == SCAN) || (state == WR)) && (next_state == DONE)) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rle_param.sv
// tb/tb_rle_param.sv - directed table-driven bench for rle_param
module tb_rle_param;

  localparam int ADDR_W = 16;
  localparam logic [31:0] MSG_A = 32'h0000_1000;
  localparam logic [31:0] RLE_A = 32'h0000_2000;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       message_addr = MSG_A;
  logic [31:0]       message_size = '0;
  logic [31:0]       rle_addr = RLE_A;
  logic [31:0]       rle_size;
  logic              done, busy;
  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic              port_A_we;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;
`ifdef RLE_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [4096];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  rle_param #(.ADDR_W(ADDR_W), .MAX_RUN(255)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
    .rle_size(rle_size), .done(done), .busy(busy),
`ifdef RLE_CHECKSUM_EN
    .checksum(checksum),
`endif
    .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge port_A_clk) begin
    if (port_A_we) begin
      mem[port_A_addr[13:2]] <= port_A_data_in;
      wa_q.push_back(32'(port_A_addr));
      wd_q.push_back(port_A_data_in);
    end
    port_A_data_out <= mem[port_A_addr[13:2]];
  end

  typedef struct {
    logic [31:0]       size;
    logic [127:0]      bytes;
    int                nw;
    logic [3:0][31:0]  w;
    logic [31:0]       rsz;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [31:0] size, input logic [127:0] bytes, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] rsz);
    vec_t v;
    v.size = size; v.bytes = bytes; v.nw = nw; v.rsz = rsz;
    v.w = {w3, w2, w1, w0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({name, "_done_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic load_bytes(input logic [127:0] b);
    for (int k = 0; k < 4; k++) mem[MSG_A[13:2] + 12'(k)] = b[32*k +: 32];
  endtask

  task automatic run_vec(input int n);
    string nm;
    nm = $sformatf("vec%0d", n);
    load_bytes(vecs[n].bytes);
    wa_q.delete(); wd_q.delete();
    message_size = vecs[n].size;
    pulse_start();
    wait_done(nm);
    chk({nm, "_nwrites"}, 32'(wd_q.size()), 32'(vecs[n].nw));
    for (int k = 0; k < vecs[n].nw; k++) begin
      chk($sformatf("%s_word%0d", nm, k), (k < wd_q.size()) ? wd_q[k] : 32'hDEAD_BEEF, vecs[n].w[k]);
      chk($sformatf("%s_addr%0d", nm, k), (k < wa_q.size()) ? wa_q[k] : 32'hDEAD_BEEF, RLE_A + 32'(4 * k));
    end
    chk({nm, "_rle_size"}, rle_size, vecs[n].rsz);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(32'd4, 128'h41414141,         1, 32'h00004104, 0, 0, 0, 32'd2);
    vecs[1] = mk(32'd6, 128'h333333222211,     2, 32'h22021101, 32'h00003303, 0, 0, 32'd6);
    vecs[2] = mk(32'd3, 128'h030201,           2, 32'h02010101, 32'h00000301, 0, 0, 32'd6);
    vecs[3] = mk(32'd5, 128'h09090909_09070707, 1, 32'h09020703, 0, 0, 0, 32'd4);
    vecs[4] = mk(32'd1, 128'h09090909,         1, 32'h00000901, 0, 0, 0, 32'd2);
    vecs[5] = mk(32'd8, 128'h08070605_04030201, 4, 32'h02010101, 32'h04010301,
                 32'h06010501, 32'h08010701, 32'd16);
    for (int k = 0; k < 4096; k++) mem[k] = 32'hA5A5_A5A5;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(port_A_we), 32'd0);
    chk("rst_addr", 32'(port_A_addr), 32'd0);
    chk("rst_data_in", port_A_data_in, 32'd0);
    chk("rst_rle_size", rle_size, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // table-driven frames, back to back (vec3 ends in 09, vec4 starts with 09)
    for (int n = 0; n < 6; n++) begin
      run_vec(n);
`ifdef RLE_CHECKSUM_EN
      if (n == 2) chk("checksum_010203", checksum, 32'h0000_0006);
`endif
    end

    // zero-length frame: no access, done two cycles after start
    wa_q.delete(); wd_q.delete();
    message_size = 32'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_c1", 32'(done), 32'd0);
    chk("zero_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("zero_done_c2", 32'(done), 32'd1);
    chk("zero_busy_c2", 32'(busy), 32'd0);
    chk("zero_nwrites", 32'(wd_q.size()), 32'd0);
    chk("zero_rle_size", rle_size, 32'd0);

    // 600 zero bytes split at MAX_RUN
    for (int k = 0; k < 150; k++) mem[MSG_A[13:2] + 12'(k)] = 32'h0;
    wa_q.delete(); wd_q.delete();
    message_size = 32'd600;
    pulse_start();
    wait_done("long");
    chk("long_nwrites", 32'(wd_q.size()), 32'd2);
    chk("long_word0", (wd_q.size() > 0) ? wd_q[0] : 32'hDEAD_BEEF, 32'h00FF00FF);
    chk("long_word1", (wd_q.size() > 1) ? wd_q[1] : 32'hDEAD_BEEF, 32'h0000005A);
    chk("long_rle_size", rle_size, 32'd6);

    // start while busy is ignored
    load_bytes(vecs[1].bytes);
    wa_q.delete(); wd_q.delete();
    message_size = vecs[1].size;
    pulse_start();
    @(negedge clk);
    message_size = 32'd0; rle_addr = 32'h0000_3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rle_addr = RLE_A;
    wait_done("busy_start");
    chk("busy_start_nwrites", 32'(wd_q.size()), 32'd2);
    chk("busy_start_word1", (wd_q.size() > 1) ? wd_q[1] : 32'hDEAD_BEEF, 32'h00003303);
    chk("busy_start_addr1", (wa_q.size() > 1) ? wa_q[1] : 32'hDEAD_BEEF, RLE_A + 32'd4);
    chk("busy_start_rle_size", rle_size, 32'd6);

    // reset mid-frame, then a clean frame with no stale run or pair
    for (int k = 0; k < 150; k++) mem[MSG_A[13:2] + 12'(k)] = 32'h0;
    message_size = 32'd600;
    pulse_start();
    repeat (300) @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("mid_rst_we", 32'(port_A_we), 32'd0);
    chk("mid_rst_addr", 32'(port_A_addr), 32'd0);
    chk("mid_rst_data_in", port_A_data_in, 32'd0);
    chk("mid_rst_rle_size", rle_size, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    run_vec(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
